pwm_ramp_sequencer: RTL and testbench
=====================================

Name: pwm_ramp_sequencer

Overview:
Controller that sequences an 8-bit PWM duty level through programmable breathing cycles: ramp up, hold, ramp down, hold, repeated N times or forever. It owns the step-rate prescaler, hold timers and cycle counter, and drives a free-running 8-bit PWM comparator. It sits between a host/config register block and the LED/PWM output pins.

Parameters:
WIDTH, 8, duty level and PWM counter width
DIV_W, 16, width of step_div and the prescaler counter
HOLD_W, 16, width of hold_ticks and the hold counter

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sequence; honoured only in IDLE
stop  input  1  abort request; honoured in any state
min_level  input  WIDTH  lower ramp limit, latched on accepted start
max_level  input  WIDTH  upper ramp limit, latched on accepted start
step_div  input  DIV_W  clocks per step tick minus 1, latched on accepted start
hold_ticks  input  HOLD_W  step ticks spent in each hold state, latched on accepted start
cycles  input  8  full breathing cycles to run, 0 = infinite, latched on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse on normal completion
state  output  3  IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4
level  output  WIDTH  current duty level
pwm_out  output  1  registered PWM output

Behaviour:
- Reset (reset low, asynchronous): state IDLE, level 0, pwm_out 0, busy 0, done 0; all internal counters 0.
- Tick generation: the prescaler runs only when state != IDLE. It asserts tick when prescaler == step_div, and the prescaler then returns to 0. step_div=0 gives a tick every clock. The prescaler clears on every state transition.
- IDLE: start=1 and stop=0 latch all config inputs, load level with min_level, clear the cycle counter and enter RAMP_UP on the next clock. busy rises in that same clock.
- RAMP_UP: on tick, if level >= max_lat, go to HOLD_HI; otherwise level+1. level never exceeds max_lat or wraps.
- HOLD_HI: level is frozen. The hold counter counts ticks. After hold_ticks ticks, go to RAMP_DN. hold_ticks=0 exits on the first clock without waiting for a tick.
- RAMP_DN: on tick, if level <= min_lat, go to HOLD_LO; otherwise level-1. level never underflows.
- HOLD_LO: hold counter behaves as in HOLD_HI. On exit, increment the cycle counter. If cycles_lat != 0 and the count equals cycles_lat, go to IDLE and pulse done for 1 clock; level stays at min_lat. Otherwise go to RAMP_UP.
- min_lat >= max_lat: both ramps exit on their first tick with no level change, so level stays at min_lat throughout.
- stop: takes priority over start and all transitions. Next clock: state IDLE, level 0, no done pulse. The PWM output goes low within 1 clock after level updates.
- start while busy is ignored; config inputs are not re-latched.
- done and start may coincide: start is ignored that cycle because state is not yet IDLE.
- PWM: pwm_cnt is a free-running WIDTH-bit counter that wraps 255->0. pwm_out <= (pwm_cnt < duty), where duty = level. level 0 gives constant low; level 255 gives high for 255 of 256 clocks. Latency from level change to pwm_out is 1 clock.

Optional Feature:
PWM_RAMP_GAMMA_EN
- Defined: duty = (level*level)>>WIDTH, registered, giving perceptual (quadratic) brightness. Latency from level to pwm_out becomes 2 clocks. Special case: level 255 maps to duty 255 so full brightness is preserved. busy, done, state and level are unchanged.
- Undefined: duty = level directly, with 1-clock latency.

Test Plan:
- Config min=0, max=4, step_div=0, hold_ticks=2, cycles=1; pulse start -> level 0,1,2,3,4 then holds, ramps 4..0, holds; done pulses exactly once; busy falls the same clock; 1 cycle takes 16 clocks ±1 (bench checks exact count).
- step_div=3, min=10, max=12 -> level changes only every 4th clock; state sequence 1,2,3,4 repeats with cycles=0 (infinite) for 3 cycles; done never asserted.
- Mid-RAMP_UP, assert stop together with start -> next clock state 0, level 0, busy 0, done 0; pwm_out low within 2 clocks.
- min=200, max=100, hold_ticks=0 -> level stays at 200 through all states; done after cycles=2.
- Hold level at 0, 128 and 255 for 512 clocks -> pwm_out high count is 0, 128 and 255 per 256 clocks. With PWM_RAMP_GAMMA_EN defined, level 128 gives 64 high clocks.
- Assert reset low mid-HOLD_HI asynchronously -> all outputs 0 immediately. After release, start is accepted on the first IDLE clock.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// Breathing-cycle PWM sequencer: ramps an 8-bit duty level up/hold/down/hold, N times or forever.
// Optional PWM_RAMP_GAMMA_EN: quadratic (perceptual) duty mapping with one extra pipeline stage.
module pwm_ramp_sequencer #(
  parameter int WIDTH  = 8,
  parameter int DIV_W  = 16,
  parameter int HOLD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [WIDTH-1:0]  min_level,
  input  logic [WIDTH-1:0]  max_level,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [HOLD_W-1:0] hold_ticks,
  input  logic [7:0]        cycles,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state,
  output logic [WIDTH-1:0]  level,
  output logic              pwm_out
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    HOLD_HI = 3'd2,
    RAMP_DN = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   level_q, level_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [7:0]         cyc_q, cyc_d;
  logic               done_d;
  logic               load;
  logic               tick;

  logic [WIDTH-1:0]   min_lat, max_lat;
  logic [DIV_W-1:0]   div_lat;
  logic [HOLD_W-1:0]  hold_lat;
  logic [7:0]         cycles_lat;

  logic [WIDTH-1:0]   pwm_cnt;
  logic [WIDTH-1:0]   duty;

  assign tick = (state_q != IDLE) && (presc_q == div_lat);

  // NOTE: every signal assigned here gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    load    = 1'b0;
    presc_d = (state_q == IDLE || tick) ? '0 : presc_q + DIV_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          level_d = min_level;
          cyc_d   = '0;
          state_d = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (tick) begin
          if (level_q >= max_lat) state_d = HOLD_HI;
          else                    level_d = level_q + WIDTH'(1);
        end
      end
      HOLD_HI: begin
        if (hold_q >= hold_lat) state_d = RAMP_DN;
        else if (tick)          hold_d  = hold_q + HOLD_W'(1);
      end
      RAMP_DN: begin
        if (tick) begin
          if (level_q <= min_lat) state_d = HOLD_LO;
          else                    level_d = level_q - WIDTH'(1);
        end
      end
      HOLD_LO: begin
        if (hold_q >= hold_lat) begin
          cyc_d = cyc_q + 8'd1;
          if (cycles_lat != '0 && cyc_d == cycles_lat) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RAMP_UP;
          end
        end else if (tick) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      presc_d = '0;
      hold_d  = '0;
    end

    // Abort wins over everything, including a start in the same cycle.
    if (stop) begin
      state_d = IDLE;
      level_d = '0;
      presc_d = '0;
      hold_d  = '0;
      done_d  = 1'b0;
      load    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      level_q    <= '0;
      presc_q    <= '0;
      hold_q     <= '0;
      cyc_q      <= '0;
      done       <= 1'b0;
      min_lat    <= '0;
      max_lat    <= '0;
      div_lat    <= '0;
      hold_lat   <= '0;
      cycles_lat <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      presc_q <= presc_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
      done    <= done_d;
      if (load) begin
        min_lat    <= min_level;
        max_lat    <= max_level;
        div_lat    <= step_div;
        hold_lat   <= hold_ticks;
        cycles_lat <= cycles;
      end
    end
  end

`ifdef PWM_RAMP_GAMMA_EN
  logic [2*WIDTH-1:0] lvl_wide;
  assign lvl_wide = {{WIDTH{1'b0}}, level_q};

  // Full scale is pinned to full scale; the square alone would top out one step short.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) duty <= '0;
    else        duty <= (&level_q) ? '1 : WIDTH'((lvl_wide * lvl_wide) >> WIDTH);
  end
`else
  assign duty = level_q;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + WIDTH'(1);
      pwm_out <= (pwm_cnt < duty);
    end
  end

  assign busy  = (state_q != IDLE);
  assign state = state_q;
  assign level = level_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_pwm_ramp_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [7:0]  min_level = '0;
  logic [7:0]  max_level = '0;
  logic [15:0] step_div = '0;
  logic [15:0] hold_ticks = '0;
  logic [7:0]  cycles = '0;
  logic        busy, done, pwm_out;
  logic [2:0]  state;
  logic [7:0]  level;

  int checks = 0;
  int errors = 0;

  pwm_ramp_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .min_level(min_level), .max_level(max_level), .step_div(step_div),
    .hold_ticks(hold_ticks), .cycles(cycles),
    .busy(busy), .done(done), .state(state), .level(level), .pwm_out(pwm_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        start, stop;
    logic [7:0]  min_l, max_l;
    logic [15:0] div, hold;
    logic [7:0]  cyc;
    logic [2:0]  e_state;
    logic [7:0]  e_level;
    logic        e_busy, e_done;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic st, input logic sp, input logic [7:0] mn, input logic [7:0] mx,
                     input logic [15:0] dv, input logic [15:0] hd, input logic [7:0] cy,
                     input logic [2:0] es, input logic [7:0] el, input logic eb, input logic ed);
    vec_t v;
    v.start = st; v.stop = sp; v.min_l = mn; v.max_l = mx; v.div = dv; v.hold = hd; v.cyc = cy;
    v.e_state = es; v.e_level = el; v.e_busy = eb; v.e_done = ed;
    vecs.push_back(v);
  endtask

  // Garbage config on non-start rows proves nothing is re-latched while busy.
  task automatic addg(input logic st, input logic [2:0] es, input logic [7:0] el,
                      input logic eb, input logic ed);
    add(st, 1'b0, 8'd50, 8'd60, 16'd7, 16'd9, 8'd3, es, el, eb, ed);
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic cfg(input logic [7:0] mn, input logic [7:0] mx, input logic [15:0] dv,
                     input logic [15:0] hd, input logic [7:0] cy);
    min_level = mn; max_level = mx; step_div = dv; hold_ticks = hd; cycles = cy;
  endtask

  task automatic do_stop();
    @(negedge clock); stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic duty_test(input logic [7:0] lv, input int exp_high, input string name);
    int high;
    @(negedge clock);
    cfg(lv, lv, 16'hFFFF, 16'hFFFF, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check({name, " level"}, level, lv);
    high = 0;
    for (int i = 0; i < 512; i++) begin
      step();
      if (pwm_out) high++;
    end
    check({name, " high"}, high, exp_high);
    do_stop();
  endtask

  initial begin
    int prev_state, trans, since, lvl_changes, done_cnt, high, lvl_prev;
    int exp128;

    // Main breathing cycle: min 0, max 4, div 0, hold 2, cycles 1.
    add(1, 0, 8'd0, 8'd4, 16'd0, 16'd2, 8'd1, 3'd1, 8'd0, 1, 0);
    addg(0, 1, 1, 1, 0);
    addg(0, 1, 2, 1, 0);
    addg(1, 1, 3, 1, 0);
    addg(0, 1, 4, 1, 0);
    addg(0, 2, 4, 1, 0);
    addg(0, 2, 4, 1, 0);
    addg(0, 2, 4, 1, 0);
    addg(0, 3, 4, 1, 0);
    addg(0, 3, 3, 1, 0);
    addg(0, 3, 2, 1, 0);
    addg(0, 3, 1, 1, 0);
    addg(0, 3, 0, 1, 0);
    addg(0, 4, 0, 1, 0);
    addg(0, 4, 0, 1, 0);
    addg(1, 4, 0, 1, 0);
    addg(1, 0, 0, 0, 1);
    addg(0, 0, 0, 0, 0);
    // Inverted limits: min 200, max 100, hold 0, cycles 2.
    add(1, 0, 8'd200, 8'd100, 16'd0, 16'd0, 8'd2, 3'd1, 8'd200, 1, 0);
    addg(0, 2, 200, 1, 0);
    addg(0, 3, 200, 1, 0);
    addg(0, 4, 200, 1, 0);
    addg(0, 1, 200, 1, 0);
    addg(0, 2, 200, 1, 0);
    addg(0, 3, 200, 1, 0);
    addg(0, 4, 200, 1, 0);
    addg(0, 0, 200, 0, 1);
    addg(0, 0, 200, 0, 0);

    // Reset state.
    #12;
    check("rst state", state, 0);
    check("rst level", level, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pwm", pwm_out, 0);
    @(negedge clock); reset = 1'b1;

    // Table-driven vectors.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      start = vecs[i].start; stop = vecs[i].stop;
      cfg(vecs[i].min_l, vecs[i].max_l, vecs[i].div, vecs[i].hold, vecs[i].cyc);
      step();
      check($sformatf("vec%0d state", i), state, vecs[i].e_state);
      check($sformatf("vec%0d level", i), level, vecs[i].e_level);
      check($sformatf("vec%0d busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d done", i), done, vecs[i].e_done);
    end
    @(negedge clock); start = 1'b0;

    // Prescaled, infinite: 12+5+12+5 = 34 clocks per cycle, level moves every 4th clock.
    @(negedge clock);
    cfg(8'd10, 8'd12, 16'd3, 16'd1, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t2 first state", state, 1);
    check("t2 first level", level, 10);
    prev_state = 1; trans = 0; since = 0; lvl_changes = 0; done_cnt = 0;
    for (int c = 1; c <= 200 && trans < 12; c++) begin
      lvl_prev = level;
      step();
      since++;
      if (done) done_cnt++;
      if (state != prev_state) begin
        check("t2 order", state, (prev_state == 4) ? 1 : prev_state + 1);
        trans++;
        since = 0;
        prev_state = state;
        if (trans == 12) check("t2 three cycle clocks", c, 102);
      end else if (level != lvl_prev) begin
        lvl_changes++;
        check("t2 step spacing", since % 4, 0);
      end
    end
    check("t2 transitions", trans, 12);
    check("t2 level changes", lvl_changes, 12);
    check("t2 no done", done_cnt, 0);
    do_stop();
    check("t2 stopped", state, 0);

    // Stop together with start mid-RAMP_UP.
    @(negedge clock);
    cfg(8'd100, 8'd200, 16'd1, 16'd0, 8'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (10) step();
    check("t3 pre state", state, 1);
    check("t3 pre level", level, 105);
    @(negedge clock); start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("t3 state", state, 0);
    check("t3 level", level, 0);
    check("t3 busy", busy, 0);
    check("t3 done", done, 0);
    step(); step();
    check("t3 pwm low", pwm_out, 0);
    check("t3 still idle", state, 0);
    high = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pwm_out) high++;
    end
    check("t3 pwm stays low", high, 0);

    // PWM duty over two full periods.
`ifdef PWM_RAMP_GAMMA_EN
    exp128 = 128;
`else
    exp128 = 256;
`endif
    duty_test(8'd0, 0, "pwm0");
    duty_test(8'd128, exp128, "pwm128");
    duty_test(8'd255, 510, "pwm255");

    // Asynchronous reset mid-HOLD_HI, then start on the first IDLE clock.
    @(negedge clock);
    cfg(8'd0, 8'd200, 16'd0, 16'd1000, 8'd0);
    max_level = 8'd200;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 400 && state != 2; i++) step();
    check("t6 in hold_hi", state, 2);
    repeat (3) step();
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    check("t6 rst state", state, 0);
    check("t6 rst level", level, 0);
    check("t6 rst busy", busy, 0);
    check("t6 rst done", done, 0);
    check("t6 rst pwm", pwm_out, 0);
    @(negedge clock);
    reset = 1'b1;
    cfg(8'd7, 8'd9, 16'd0, 16'd0, 8'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t6 restart state", state, 1);
    check("t6 restart level", level, 7);
    check("t6 restart busy", busy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
